slice_ff_bank: RTL and testbench

- Verilator-compatible behavioural model of a bank of slice storage flops, sitting directly downstream of the wide-function muxes (MUXF7/MUXF8 local outputs) in a CLB.
- Each bit is an FDCE- or FDPE-style register: clock enable, asynchronous clear/preset, and power-up INIT.
- Includes a harness-visible per-bit output override (force flag and force value) for fast state injection during co-simulation.
- Exposes a scope cell-kind constant so the harness can identify the cell.

---
 rtl/xil_prim_pkg.sv | 18 +
 rtl/slice_ff_cell.sv | 33 +++
 rtl/slice_ff_bank.sv | 51 +++++
 tb/tb_slice_ff_bank.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/xil_prim_pkg.sv
// Shared primitive package: cell-kind identifiers used by the co-sim harness
// and the reset-value helper for slice storage flops.
package xil_prim_pkg;

    typedef logic [7:0] cell_kind_t;

    localparam cell_kind_t MUXF7_KIND    = 8'd5;
    localparam cell_kind_t MUXF7_L_KIND  = 8'd6;
    localparam cell_kind_t MUXF8_KIND    = 8'd7;
    localparam cell_kind_t SLICE_FF_KIND = 8'd8;

    // Value a flop bit takes while CLR is high: FDPE bits preset, FDCE bits clear.
    function automatic logic ff_rst_bit(input logic [63:0] preset_mask,
                                        input int          idx);
        return preset_mask[idx];
    endfunction

endpackage

// File: rtl/slice_ff_cell.sv
// One slice storage flop (FDCE/FDPE style) with CE, async CLR and power-up INIT.
// Ports: C clock, CLR async clear/preset, CE enable, D data, Q registered out.
module slice_ff_cell #(
    parameter logic INIT_BIT          = 1'b0,
    parameter logic PRESET_BIT        = 1'b0,
    parameter logic IS_C_INVERTED     = 1'b0,
    parameter logic IS_D_INVERTED_BIT = 1'b0
) (
    input  logic C,
    input  logic CLR,
    input  logic CE,
    input  logic D,
    output logic Q
);

    logic w_clk;
    logic r_q = INIT_BIT;

    // Falling-edge operation is obtained by inverting the clock ahead of the flop.
    assign w_clk = C ^ IS_C_INVERTED;

    // An X on CE falls through to the hold branch.
    always_ff @(posedge w_clk or posedge CLR) begin
        if (CLR) begin
            r_q <= PRESET_BIT;
        end else if (CE) begin
            r_q <= D ^ IS_D_INVERTED_BIT;
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/slice_ff_bank.sv
// Bank of WIDTH slice flops fed by the wide-function muxes, with an optional
// harness-written per-bit output override (FAST_IQ build) and scope cell kind.
// Ports: C clock, CLR async clear/preset, CE shared enable, D data in, Q out.
module slice_ff_bank
    import xil_prim_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] INIT          = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PRESET_MASK   = {WIDTH{1'b0}},
    parameter logic             IS_C_INVERTED = 1'b0,
    parameter logic [WIDTH-1:0] IS_D_INVERTED = {WIDTH{1'b0}},
    parameter bit               FAST_IQ       = 1'b0
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] w_state;
    cell_kind_t       cell_kind;

    assign cell_kind = SLICE_FF_KIND;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        slice_ff_cell #(
            .INIT_BIT         (INIT[i]),
            .PRESET_BIT       (ff_rst_bit(64'(PRESET_MASK), i)),
            .IS_C_INVERTED    (IS_C_INVERTED),
            .IS_D_INVERTED_BIT(IS_D_INVERTED[i])
        ) u_cell (
            .C  (C),
            .CLR(CLR),
            .CE (CE),
            .D  (D[i]),
            .Q  (w_state[i])
        );
    end

    if (FAST_IQ) begin : g_fiq
        // Written only by the harness; CLR deliberately leaves them alone.
        logic [WIDTH-1:0] Q_f = '0;
        logic [WIDTH-1:0] Q_v = '0;

        assign Q = (w_state & ~Q_f) | (Q_v & Q_f);
    end else begin : g_plain
        assign Q = w_state;
    end

endmodule

// File: tb/tb_slice_ff_bank.sv
// Directed bench for slice_ff_bank: rising-edge fast-IQ bank plus a
// falling-edge bank with D inversion.
module tb_slice_ff_bank;

    logic       C, CLR, CE;
    logic [7:0] D, Q;
    logic       C2, CLR2, CE2;
    logic [7:0] D2, Q2;

    int n_chk  = 0;
    int n_fail = 0;

    slice_ff_bank #(
        .WIDTH        (8),
        .INIT         (8'hA5),
        .PRESET_MASK  (8'h0F),
        .IS_C_INVERTED(1'b0),
        .IS_D_INVERTED(8'h00),
        .FAST_IQ      (1'b1)
    ) dut (
        .C  (C),
        .CLR(CLR),
        .CE (CE),
        .D  (D),
        .Q  (Q)
    );

    slice_ff_bank #(
        .WIDTH        (8),
        .INIT         (8'h00),
        .PRESET_MASK  (8'h00),
        .IS_C_INVERTED(1'b1),
        .IS_D_INVERTED(8'h01),
        .FAST_IQ      (1'b0)
    ) dut2 (
        .C  (C2),
        .CLR(CLR2),
        .CE (CE2),
        .D  (D2),
        .Q  (Q2)
    );

    task automatic check(input string tag,
                         input logic [7:0] act,
                         input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Full rising-edge clock cycle on bank 1.
    task automatic tick();
        #4 C = 1'b1;
        #5 C = 1'b0;
        #1;
    endtask

    initial begin
        C = 0; CLR = 0; CE = 0; D = 8'h00;
        C2 = 0; CLR2 = 0; CE2 = 0; D2 = 8'h00;

        // Power-up value, no clock, no reset.
        #1;
        check("init", Q, 8'hA5);
        check("cell_kind", dut.cell_kind, 8'd8);

        // CLR pulse between edges: immediate, held after release.
        CLR = 1;
        #1 check("clr_now", Q, 8'h0F);
        #2 CLR = 0;
        #1 check("clr_rel", Q, 8'h0F);

        // Enabled capture, then hold with CE low.
        CE = 1; D = 8'h3C;
        #4 C = 1;
        #1 check("cap_3c", Q, 8'h3C);
        #4 C = 0;
        #1;
        CE = 0; D = 8'hFF;
        for (int i = 0; i < 4; i++) tick();
        check("hold_ce0", Q, 8'h3C);

        // CLR and the active edge in the same timestep.
        CE = 1; D = 8'h55;
        #4;
        C = 1; CLR = 1;
        #1 check("clr_vs_edge", Q, 8'h0F);
        #4 C = 0;
        #2 CLR = 0;
        #1 check("clr_fall", Q, 8'h0F);
        #2 C = 1;
        #1 check("post_clr_cap", Q, 8'h55);
        #4 C = 0;
        #1;

        // Override: state 00, force bit 7 high.
        D = 8'h00;
        tick();
        check("state_00", dut.w_state, 8'h00);
        dut.g_fiq.Q_f = 8'h80;
        dut.g_fiq.Q_v = 8'h80;
        #1 check("ovr_80", Q, 8'h80);
        D = 8'h01;
        tick();
        check("ovr_81", Q, 8'h81);
        dut.g_fiq.Q_f = 8'h00;
        #1 check("ovr_clr", Q, 8'h01);

        // Override survives CLR while state is reset underneath.
        dut.g_fiq.Q_f = 8'hFF;
        dut.g_fiq.Q_v = 8'h00;
        #1 CLR = 1;
        #1 check("ovr_clr_q", Q, 8'h00);
        check("ovr_clr_st", dut.w_state, 8'h0F);
        dut.g_fiq.Q_f = 8'h00;
        #1 check("ovr_rel", Q, 8'h0F);
        CLR = 0;
        #1;

        // Falling-edge bank with D bit 0 inverted.
        CLR2 = 1;
        #1 check("b2_clr", Q2, 8'h00);
        CLR2 = 0; CE2 = 1; D2 = 8'h10;
        #2 C2 = 1;
        #1 check("b2_rise", Q2, 8'h00);
        #4 C2 = 0;
        #1 check("b2_fall", Q2, 8'h11);
        CE2 = 0; D2 = 8'hF0;
        #4 C2 = 1;
        #4 C2 = 0;
        #1 check("b2_hold", Q2, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
